// File: rtl/mvm_uart_host.sv
// Host-side UART bridge: packed K/X AXI-Stream word -> UART bytes; UART bytes -> wide Y AXI-Stream word.
// Latency: TX start bit the cycle after handshake; Y word valid the cycle after the last stop-bit sample.
// Backpressure: kx_tready low while a word is being sent; a Y word completing while one is still held is dropped.
module mvm_uart_host #(
    parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
    parameter int BITS_PER_WORD    = 8,
    parameter int PACKET_SIZE_TX   = BITS_PER_WORD + 5,
    parameter int W_KX             = 12,
    parameter int W_Y              = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_axis_kx_tvalid,
    output logic            s_axis_kx_tready,
    input  logic [W_KX-1:0] s_axis_kx_tdata,
    output logic            tx,
    input  logic            rx,
    output logic            m_axis_y_tvalid,
    input  logic            m_axis_y_tready,
    output logic [W_Y-1:0]  m_axis_y_tdata,
    output logic            rx_frame_err,
    output logic            rx_overrun
);

    localparam int N_TX = (W_KX + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int N_RX = W_Y / BITS_PER_WORD;
    localparam int CW   = $clog2(CLOCKS_PER_PULSE);
    localparam int PW   = $clog2(PACKET_SIZE_TX);
    localparam int TW   = (N_TX > 1) ? $clog2(N_TX) : 1;
    localparam int DW   = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int RW   = (N_RX > 1) ? $clog2(N_RX) : 1;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [PW-1:0] PKT_LAST  = PW'(PACKET_SIZE_TX - 1);
    localparam logic [PW-1:0] DATA_END  = PW'(BITS_PER_WORD);
    localparam logic [TW-1:0] TXB_LAST  = TW'(N_TX - 1);
    localparam logic [DW-1:0] RXB_LAST  = DW'(BITS_PER_WORD - 1);
    localparam logic [RW-1:0] WORD_LAST = RW'(N_RX - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t                   tx_state, tx_state_n;
    logic [CW-1:0]               tx_clk, tx_clk_n;
    logic [PW-1:0]               tx_bit, tx_bit_n;
    logic [TW-1:0]               tx_byte, tx_byte_n;
    logic [N_TX*BITS_PER_WORD-1:0] tx_buf, tx_buf_n;
    logic [BITS_PER_WORD-1:0]    tx_cur;
    logic [BITS_PER_WORD:0]      tx_frame;
    logic                        tx_n;

    // tx is registered from next-state values so the line is glitch-free yet the start bit still lands right after the handshake
    always_comb begin
        tx_state_n = tx_state;
        tx_clk_n   = tx_clk;
        tx_bit_n   = tx_bit;
        tx_byte_n  = tx_byte;
        tx_buf_n   = tx_buf;
        case (tx_state)
            TX_IDLE: begin
                if (s_axis_kx_tvalid) begin
                    tx_state_n             = TX_SEND;
                    tx_buf_n               = '0;
                    tx_buf_n[W_KX-1:0]     = s_axis_kx_tdata;
                    tx_clk_n               = '0;
                    tx_bit_n               = '0;
                    tx_byte_n              = '0;
                end
            end
            TX_SEND: begin
                if (tx_clk == CLK_LAST) begin
                    tx_clk_n = '0;
                    if (tx_bit == PKT_LAST) begin
                        tx_bit_n = '0;
                        if (tx_byte == TXB_LAST) tx_state_n = TX_IDLE;
                        else                     tx_byte_n  = tx_byte + 1'b1;
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end else begin
                    tx_clk_n = tx_clk + 1'b1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        tx_cur   = tx_buf_n[tx_byte_n*BITS_PER_WORD +: BITS_PER_WORD];
        tx_frame = {tx_cur, 1'b0};
        tx_n     = 1'b1;
        if (tx_state_n == TX_SEND && tx_bit_n <= DATA_END) tx_n = tx_frame[tx_bit_n];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= TX_IDLE;
            tx_clk   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_buf   <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_clk   <= tx_clk_n;
            tx_bit   <= tx_bit_n;
            tx_byte  <= tx_byte_n;
            tx_buf   <= tx_buf_n;
            tx       <= tx_n;
        end
    end

    assign s_axis_kx_tready = (tx_state == TX_IDLE);

    logic                     rx_meta, rx_sync, rx_prev;
    rx_state_t                rx_state, rx_state_n;
    logic [CW-1:0]            rx_clk, rx_clk_n;
    logic [DW-1:0]            rx_bit, rx_bit_n;
    logic                     rx_shift_en, stop_ok, stop_bad, word_done;
    logic [BITS_PER_WORD-1:0] rx_shift;
    logic [RW-1:0]            rx_cnt;
    logic [W_Y-1:0]           rx_asm, asm_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_clk_n    = rx_clk;
        rx_bit_n    = rx_bit;
        rx_shift_en = 1'b0;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_n = RX_START;
                    rx_clk_n   = '0;
                end
            end
            RX_START: begin
                if (rx_clk == HALF_LAST) begin
                    rx_clk_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_clk_n = rx_clk + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_clk == CLK_LAST) begin
                    rx_clk_n    = '0;
                    rx_shift_en = 1'b1;
                    if (rx_bit == RXB_LAST) rx_state_n = RX_STOP;
                    else                    rx_bit_n   = rx_bit + 1'b1;
                end else begin
                    rx_clk_n = rx_clk + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_clk == CLK_LAST) begin
                    rx_clk_n   = '0;
                    rx_state_n = RX_IDLE;
                    stop_ok    = rx_sync;
                    stop_bad   = !rx_sync;
                end else begin
                    rx_clk_n = rx_clk + 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_comb begin
        asm_full = rx_asm;
        asm_full[rx_cnt*BITS_PER_WORD +: BITS_PER_WORD] = rx_shift;
    end

    assign word_done = stop_ok && (rx_cnt == WORD_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state        <= RX_IDLE;
            rx_clk          <= '0;
            rx_bit          <= '0;
            rx_shift        <= '0;
            rx_cnt          <= '0;
            rx_asm          <= '0;
            m_axis_y_tvalid <= 1'b0;
            m_axis_y_tdata  <= '0;
            rx_frame_err    <= 1'b0;
            rx_overrun      <= 1'b0;
        end else begin
            rx_state     <= rx_state_n;
            rx_clk       <= rx_clk_n;
            rx_bit       <= rx_bit_n;
            rx_frame_err <= stop_bad;
            rx_overrun   <= 1'b0;
            if (rx_shift_en) rx_shift <= {rx_sync, rx_shift[BITS_PER_WORD-1:1]};
            // a bad stop bit throws away the whole partial word, not just the byte
            if (stop_bad) begin
                rx_cnt <= '0;
            end else if (stop_ok) begin
                rx_asm <= asm_full;
                rx_cnt <= (rx_cnt == WORD_LAST) ? '0 : rx_cnt + 1'b1;
            end
            if (word_done && (!m_axis_y_tvalid || m_axis_y_tready)) begin
                m_axis_y_tdata  <= asm_full;
                m_axis_y_tvalid <= 1'b1;
            end else begin
                if (word_done) rx_overrun <= 1'b1;
                if (m_axis_y_tvalid && m_axis_y_tready) m_axis_y_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mvm_uart_host.sv
// Directed bench for mvm_uart_host: TX frames decoded at mid-bit, RX words checked through an expected-word queue.
module tb_mvm_uart_host;
    localparam int CPP = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s_axis_kx_tvalid = 1'b0;
    logic        s_axis_kx_tready;
    logic [11:0] s_axis_kx_tdata = '0;
    logic        tx;
    logic        rx = 1'b1;
    logic        m_axis_y_tvalid;
    logic        m_axis_y_tready = 1'b1;
    logic [63:0] m_axis_y_tdata;
    logic        rx_frame_err;
    logic        rx_overrun;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    int y_cnt = 0;
    logic [7:0]  tx_exp[$];
    logic [63:0] y_exp[$];

    mvm_uart_host #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD(8),
        .PACKET_SIZE_TX(13),
        .W_KX(12),
        .W_Y(64)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s_axis_kx_tvalid(s_axis_kx_tvalid),
        .s_axis_kx_tready(s_axis_kx_tready),
        .s_axis_kx_tdata(s_axis_kx_tdata),
        .tx(tx),
        .rx(rx),
        .m_axis_y_tvalid(m_axis_y_tvalid),
        .m_axis_y_tready(m_axis_y_tready),
        .m_axis_y_tdata(m_axis_y_tdata),
        .rx_frame_err(rx_frame_err),
        .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (rx_frame_err) err_cnt++;
        if (rx_overrun) ovr_cnt++;
        if (m_axis_y_tvalid && m_axis_y_tready) begin
            y_cnt++;
            if (y_exp.size() == 0) begin
                total++;
                bad++;
                $error("FAIL y_unexpected observed=%0h expected=none", m_axis_y_tdata);
            end else begin
                check("y_word", m_axis_y_tdata, y_exp.pop_front());
            end
        end
    end

    task automatic send_kx(input logic [11:0] kx);
        tx_exp.push_back(kx[7:0]);
        tx_exp.push_back({4'h0, kx[11:8]});
        s_axis_kx_tdata  = kx;
        s_axis_kx_tvalid = 1'b1;
        @(negedge clk);
        s_axis_kx_tvalid = 1'b0;
    endtask

    task automatic watch_tx(input string tag);
        logic [25:0] s;
        logic [7:0]  d;
        logic [3:0]  stp;
        int busy = 0;
        s = '0;
        for (int k = 0; k < 2 * 13 * CPP; k++) begin
            if (!s_axis_kx_tready) busy++;
            if (k % CPP == CPP / 2) s[k / CPP] = tx;
            @(negedge clk);
        end
        check({tag, "_busy"}, busy, 208);
        check({tag, "_ready_after"}, s_axis_kx_tready, 1);
        check({tag, "_idle_after"}, tx, 1);
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 8; i++) d[i] = s[j*13 + 1 + i];
            for (int i = 0; i < 4; i++) stp[i] = s[j*13 + 9 + i];
            check({tag, "_start"}, s[j*13], 0);
            check({tag, "_stop"}, stp, 4'hF);
            check({tag, "_byte"}, d, tx_exp.pop_front());
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPP) @(negedge clk);
        end
        rx = stop;
        repeat (CPP) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (CPP) @(negedge clk);
    endtask

    task automatic rx_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) rx_frame(w[i*8 +: 8], 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (y_exp.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, y_exp.size(), 0);
    endtask

    initial begin
        int e0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tready", s_axis_kx_tready, 1);
        check("rst_tvalid", m_axis_y_tvalid, 0);
        check("rst_tdata", m_axis_y_tdata, 0);
        check("rst_err", rx_frame_err, 0);
        check("rst_ovr", rx_overrun, 0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        check("kx_ready_idle", s_axis_kx_tready, 1);
        send_kx(12'hA5C);
        watch_tx("kx_a5c");
        send_kx(12'h3F1);
        watch_tx("kx_3f1");

        y_exp.push_back(64'hFFFF_FFFE_0000_0003);
        rx_word(64'hFFFF_FFFE_0000_0003);
        wait_drain("y1_drain");
        check("y1_count", y_cnt, 1);

        e0 = err_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_err", err_cnt, e0);
        check("glitch_no_word", y_cnt, 1);
        y_exp.push_back(64'h0123_4567_89AB_CDEF);
        rx_word(64'h0123_4567_89AB_CDEF);
        wait_drain("y2_drain");
        check("y2_count", y_cnt, 2);

        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        rx_frame(8'h33, 1'b1);
        rx_frame(8'h44, 1'b0);
        repeat (10) @(negedge clk);
        check("ferr_pulse", err_cnt, e0 + 1);
        check("ferr_no_word", y_cnt, 2);
        y_exp.push_back(64'h8000_0000_7FFF_FFFF);
        rx_word(64'h8000_0000_7FFF_FFFF);
        wait_drain("y3_drain");
        check("y3_count", y_cnt, 3);

        m_axis_y_tready = 1'b0;
        y_exp.push_back(64'hDEAD_BEEF_CAFE_F00D);
        rx_word(64'hDEAD_BEEF_CAFE_F00D);
        repeat (10) @(negedge clk);
        check("hold_vld", m_axis_y_tvalid, 1);
        check("hold_dat", m_axis_y_tdata, 64'hDEAD_BEEF_CAFE_F00D);
        rx_word(64'h1111_2222_3333_4444);
        repeat (10) @(negedge clk);
        check("ovr_pulse", ovr_cnt, 1);
        check("ovr_vld", m_axis_y_tvalid, 1);
        check("ovr_dat_kept", m_axis_y_tdata, 64'hDEAD_BEEF_CAFE_F00D);
        check("ovr_no_pop", y_cnt, 3);
        m_axis_y_tready = 1'b1;
        wait_drain("y4_drain");
        repeat (5) @(negedge clk);
        check("ovr_vld_fall", m_axis_y_tvalid, 0);
        check("ovr_dropped", y_cnt, 4);

        m_axis_y_tready = 1'b0;
        rx_word(64'h5555_AAAA_0F0F_F0F0);
        repeat (10) @(negedge clk);
        check("pre_rst_vld", m_axis_y_tvalid, 1);
        send_kx(12'h777);
        repeat (30) @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_tready", s_axis_kx_tready, 1);
        check("midrst_tvalid", m_axis_y_tvalid, 0);
        check("midrst_tdata", m_axis_y_tdata, 0);
        tx_exp.delete();
        repeat (3) @(negedge clk);
        rx = 1'b1;
        rstn = 1'b1;
        m_axis_y_tready = 1'b1;
        repeat (20) @(negedge clk);
        check("postrst_tx_idle", tx, 1);
        send_kx(12'hC3A);
        watch_tx("kx_postrst");
        y_exp.push_back(64'h0706_0504_0302_0100);
        rx_word(64'h0706_0504_0302_0100);
        wait_drain("y5_drain");
        check("y5_count", y_cnt, 5);
        check("final_err", err_cnt, 1);
        check("final_ovr", ovr_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
